// File: rtl/rc4_ctrl_pkg.sv
// Shared types and defaults for the RC4 stream controller.
package rc4_ctrl_pkg;

    localparam int MAX_KEY_DEF = 32;
    localparam int MAX_MSG_DEF = 32;
    localparam int TIMEOUT_DEF = 2048;
    localparam int LEN_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_KEY,
        ST_KEY_XFER,
        ST_WAIT_PT,
        ST_PT_XFER,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    function automatic logic len_ok(
        input logic [LEN_W-1:0] len,
        input int               max_len
    );
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/rc4_byte_buf.sv
// Byte register file: one synchronous write port, one async read port.
module rc4_byte_buf
    import rc4_ctrl_pkg::*;
#(
    parameter int DEPTH = MAX_MSG_DEF,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          wr,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rc4_stream_ctrl.sv
// Job sequencer around one rc4 core: feeds key and plaintext,
// captures ciphertext and streams it back to the host.
module rc4_stream_ctrl
    import rc4_ctrl_pkg::*;
#(
    parameter int MAX_KEY = MAX_KEY_DEF,
    parameter int MAX_MSG = MAX_MSG_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       CLK_IN,
    input  logic       RESET_N_IN,
    input  logic       KEY_WR_IN,
    input  logic [4:0] KEY_ADDR_IN,
    input  logic [7:0] KEY_DATA_IN,
    input  logic       MSG_WR_IN,
    input  logic [4:0] MSG_ADDR_IN,
    input  logic [7:0] MSG_DATA_IN,
    input  logic [5:0] KEY_LEN_IN,
    input  logic [5:0] MSG_LEN_IN,
    input  logic       GO_IN,
    input  logic       ABORT_IN,
    output logic       BUSY_OUT,
    output logic       DONE_OUT,
    output logic       ERROR_OUT,
    output logic       OUT_VALID_OUT,
    output logic [7:0] OUT_DATA_OUT,
    input  logic       OUT_READY_IN,
    output logic       RC4_START_OUT,
    output logic       RC4_STOP_OUT,
    output logic       RC4_HOLD_OUT,
    output logic [7:0] RC4_KEY_SIZE_OUT,
    output logic [7:0] RC4_KEY_BYTE_OUT,
    output logic [7:0] RC4_PLAIN_BYTE_OUT,
    input  logic       RC4_START_KEY_CPY_IN,
    input  logic       RC4_BUSY_IN,
    input  logic       RC4_READ_PLAINTEXT_IN,
    input  logic [7:0] RC4_ENC_BYTE_IN
);

    localparam int AW = 5;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    TMO_ONE  = TW'(1);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

    state_t           state;
    logic [LEN_W-1:0] key_len;
    logic [LEN_W-1:0] msg_len;
    logic [LEN_W-1:0] key_cnt;
    logic [LEN_W-1:0] pt_cnt;
    logic [LEN_W-1:0] cap_cnt;
    logic [LEN_W-1:0] rd_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             cap_en;

    logic [LEN_W-1:0] key_nxt;
    logic [LEN_W-1:0] pt_nxt;
    logic [LEN_W-1:0] rd_nxt;
    logic [7:0]       key_rd;
    logic [7:0]       msg_rd;
    logic [7:0]       cip_rd;
    logic             idle;
    logic             cap_wr;
    logic             tmo_hit;
    logic             unused_bits;

    assign idle    = (state == ST_IDLE);
    assign key_nxt = key_cnt + ONE;
    assign pt_nxt  = pt_cnt + ONE;
    assign rd_nxt  = rd_cnt + ONE;
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign cap_wr  = cap_en &&
                     (state == ST_PT_XFER || state == ST_DRAIN);

    assign RC4_HOLD_OUT = 1'b0;
    assign unused_bits  = ^{RC4_BUSY_IN, key_nxt[LEN_W-1],
                            pt_nxt[LEN_W-1], rd_nxt[LEN_W-1]};

    // Read addresses look one byte ahead so the next byte
    // is ready to register on the following edge.
    rc4_byte_buf #(.DEPTH(MAX_KEY), .AW(AW)) u_key_buf (
        .clk   (CLK_IN),
        .wr    (KEY_WR_IN && idle),
        .waddr (KEY_ADDR_IN),
        .wdata (KEY_DATA_IN),
        .raddr ((state == ST_KEY_XFER) ? key_nxt[AW-1:0] : '0),
        .rdata (key_rd)
    );

    rc4_byte_buf #(.DEPTH(MAX_MSG), .AW(AW)) u_msg_buf (
        .clk   (CLK_IN),
        .wr    (MSG_WR_IN && idle),
        .waddr (MSG_ADDR_IN),
        .wdata (MSG_DATA_IN),
        .raddr ((state == ST_PT_XFER) ? pt_nxt[AW-1:0] : '0),
        .rdata (msg_rd)
    );

    rc4_byte_buf #(.DEPTH(MAX_MSG), .AW(AW)) u_cip_buf (
        .clk   (CLK_IN),
        .wr    (cap_wr),
        .waddr (cap_cnt[AW-1:0]),
        .wdata (RC4_ENC_BYTE_IN),
        .raddr (OUT_VALID_OUT ? rd_nxt[AW-1:0] : rd_cnt[AW-1:0]),
        .rdata (cip_rd)
    );

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state              <= ST_IDLE;
            key_len            <= '0;
            msg_len            <= '0;
            key_cnt            <= '0;
            pt_cnt             <= '0;
            cap_cnt            <= '0;
            rd_cnt             <= '0;
            tmo_cnt            <= '0;
            cap_en             <= 1'b0;
            BUSY_OUT           <= 1'b0;
            DONE_OUT           <= 1'b0;
            ERROR_OUT          <= 1'b0;
            OUT_VALID_OUT      <= 1'b0;
            OUT_DATA_OUT       <= '0;
            RC4_START_OUT      <= 1'b0;
            RC4_STOP_OUT       <= 1'b0;
            RC4_KEY_SIZE_OUT   <= '0;
            RC4_KEY_BYTE_OUT   <= '0;
            RC4_PLAIN_BYTE_OUT <= '0;
        end else begin
            RC4_START_OUT <= 1'b0;
            RC4_STOP_OUT  <= 1'b0;
            DONE_OUT      <= 1'b0;
            ERROR_OUT     <= 1'b0;
            if (ABORT_IN && !idle) begin
                state              <= ST_IDLE;
                RC4_STOP_OUT       <= 1'b1;
                BUSY_OUT           <= 1'b0;
                OUT_VALID_OUT      <= 1'b0;
                RC4_KEY_BYTE_OUT   <= '0;
                RC4_PLAIN_BYTE_OUT <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (GO_IN) begin
                            if (len_ok(KEY_LEN_IN, MAX_KEY) &&
                                len_ok(MSG_LEN_IN, MAX_MSG)) begin
                                key_len          <= KEY_LEN_IN;
                                msg_len          <= MSG_LEN_IN;
                                RC4_KEY_SIZE_OUT <= {2'b00, KEY_LEN_IN};
                                BUSY_OUT         <= 1'b1;
                                RC4_START_OUT    <= 1'b1;
                                state            <= ST_START;
                            end else begin
                                ERROR_OUT <= 1'b1;
                            end
                        end
                    end
                    ST_START: begin
                        tmo_cnt <= '0;
                        key_cnt <= '0;
                        state   <= ST_WAIT_KEY;
                    end
                    ST_WAIT_KEY: begin
                        if (RC4_START_KEY_CPY_IN) begin
                            RC4_KEY_BYTE_OUT <= key_rd;
                            state            <= ST_KEY_XFER;
                        end else if (tmo_hit) begin
                            RC4_STOP_OUT <= 1'b1;
                            ERROR_OUT    <= 1'b1;
                            BUSY_OUT     <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_ONE;
                        end
                    end
                    ST_KEY_XFER: begin
                        if (key_cnt == key_len - ONE) begin
                            RC4_KEY_BYTE_OUT <= '0;
                            tmo_cnt          <= '0;
                            state            <= ST_WAIT_PT;
                        end else begin
                            RC4_KEY_BYTE_OUT <= key_rd;
                            key_cnt          <= key_nxt;
                        end
                    end
                    ST_WAIT_PT: begin
                        if (RC4_READ_PLAINTEXT_IN) begin
                            RC4_PLAIN_BYTE_OUT <= msg_rd;
                            pt_cnt             <= '0;
                            cap_cnt            <= '0;
                            cap_en             <= 1'b0;
                            state              <= ST_PT_XFER;
                        end else if (tmo_hit) begin
                            RC4_STOP_OUT <= 1'b1;
                            ERROR_OUT    <= 1'b1;
                            BUSY_OUT     <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_ONE;
                        end
                    end
                    ST_PT_XFER: begin
                        // Core output lags the plaintext by two edges,
                        // so the last capture always lands in DRAIN.
                        cap_en <= 1'b1;
                        if (cap_wr) begin
                            cap_cnt <= cap_cnt + ONE;
                        end
                        if (pt_cnt == msg_len - ONE) begin
                            RC4_PLAIN_BYTE_OUT <= '0;
                            state              <= ST_DRAIN;
                        end else begin
                            RC4_PLAIN_BYTE_OUT <= msg_rd;
                            pt_cnt             <= pt_nxt;
                        end
                    end
                    ST_DRAIN: begin
                        if (cap_cnt == msg_len - ONE) begin
                            RC4_STOP_OUT <= 1'b1;
                            rd_cnt       <= '0;
                            state        <= ST_OUTPUT;
                        end else begin
                            cap_cnt <= cap_cnt + ONE;
                        end
                    end
                    ST_OUTPUT: begin
                        if (!OUT_VALID_OUT) begin
                            OUT_VALID_OUT <= 1'b1;
                            OUT_DATA_OUT  <= cip_rd;
                        end else if (OUT_READY_IN) begin
                            if (rd_cnt == msg_len - ONE) begin
                                OUT_VALID_OUT <= 1'b0;
                                DONE_OUT      <= 1'b1;
                                BUSY_OUT      <= 1'b0;
                                state         <= ST_IDLE;
                            end else begin
                                OUT_DATA_OUT <= cip_rd;
                                rd_cnt       <= rd_nxt;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Directed bench for rc4_stream_ctrl with a behavioural rc4 core stub.
module tb_rc4_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_wr = 1'b0;
    logic [4:0] key_addr = '0;
    logic [7:0] key_data = '0;
    logic       msg_wr = 1'b0;
    logic [4:0] msg_addr = '0;
    logic [7:0] msg_data = '0;
    logic [5:0] key_len = '0;
    logic [5:0] msg_len = '0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;
    logic       busy, done, error, valid;
    logic [7:0] data;
    logic       rc4_start, rc4_stop, rc4_hold;
    logic [7:0] rc4_ksize, rc4_kbyte, rc4_pbyte;
    logic       cpy = 1'b0;
    logic       rc4_busy = 1'b0;
    logic       rdpt = 1'b0;
    logic [7:0] enc = '0;

    int checks = 0;
    int errors = 0;

    logic [255:0] g_key = 256'hae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405;
    logic [255:0] g_pt  = 256'h3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595;
    logic [255:0] g_ct  = 256'h2280c9676c8f5c52aba8d42611f85e7ca961a2117d3cfc8236a6051bbfc5f179;

    logic [7:0] got [32];
    int ngot, ndone, nerr, stall_bad, busy_end;
    logic [7:0] ksz;

    always #5 clk = ~clk;

    rc4_stream_ctrl dut (
        .CLK_IN                (clk),
        .RESET_N_IN            (rst_n),
        .KEY_WR_IN             (key_wr),
        .KEY_ADDR_IN           (key_addr),
        .KEY_DATA_IN           (key_data),
        .MSG_WR_IN             (msg_wr),
        .MSG_ADDR_IN           (msg_addr),
        .MSG_DATA_IN           (msg_data),
        .KEY_LEN_IN            (key_len),
        .MSG_LEN_IN            (msg_len),
        .GO_IN                 (go),
        .ABORT_IN              (abort),
        .BUSY_OUT              (busy),
        .DONE_OUT              (done),
        .ERROR_OUT             (error),
        .OUT_VALID_OUT         (valid),
        .OUT_DATA_OUT          (data),
        .OUT_READY_IN          (ready),
        .RC4_START_OUT         (rc4_start),
        .RC4_STOP_OUT          (rc4_stop),
        .RC4_HOLD_OUT          (rc4_hold),
        .RC4_KEY_SIZE_OUT      (rc4_ksize),
        .RC4_KEY_BYTE_OUT      (rc4_kbyte),
        .RC4_PLAIN_BYTE_OUT    (rc4_pbyte),
        .RC4_START_KEY_CPY_IN  (cpy),
        .RC4_BUSY_IN           (rc4_busy),
        .RC4_READ_PLAINTEXT_IN (rdpt),
        .RC4_ENC_BYTE_IN       (enc)
    );

    // Core stub: real RC4 keystream, core-side handshake timing.
    typedef enum {C_IDLE, C_DLY, C_CPY, C_KEY, C_PDLY, C_E0, C_PT} cst_t;
    cst_t       cst = C_IDLE;
    int         c_cnt, c_k, c_ksz, si, sj;
    logic [7:0] kb [32];
    logic [7:0] sb [256];
    bit         stub_en = 1'b1;

    task automatic rc4_ksa();
        int j;
        logic [7:0] t;
        j = 0;
        for (int i = 0; i < 256; i++) sb[i] = 8'(i);
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(sb[i]) + int'(kb[i % c_ksz])) % 256;
            t = sb[i];
            sb[i] = sb[j];
            sb[j] = t;
        end
        si = 0;
        sj = 0;
    endtask

    task automatic rc4_next(output logic [7:0] ks);
        logic [7:0] t;
        si = (si + 1) % 256;
        sj = (sj + int'(sb[si])) % 256;
        t = sb[si];
        sb[si] = sb[sj];
        sb[sj] = t;
        ks = sb[(int'(sb[si]) + int'(sb[sj])) % 256];
    endtask

    always @(posedge clk) begin : core_stub
        logic [7:0] ks;
        if (!rst_n || rc4_stop) begin
            cst = C_IDLE;
            cpy <= 1'b0;
            rdpt <= 1'b0;
        end else if (rc4_start) begin
            cst = C_DLY;
            c_cnt = 0;
            cpy <= 1'b0;
            rdpt <= 1'b0;
        end else begin
            case (cst)
                C_DLY: begin
                    c_cnt++;
                    if (stub_en && c_cnt == 3) begin
                        cpy <= 1'b1;
                        cst = C_CPY;
                    end
                end
                C_CPY: begin
                    cpy <= 1'b0;
                    c_k = 0;
                    c_ksz = int'(rc4_ksize);
                    cst = C_KEY;
                end
                C_KEY: begin
                    kb[c_k] = rc4_kbyte;
                    c_k++;
                    if (c_k >= c_ksz) begin
                        rc4_ksa();
                        c_cnt = 0;
                        cst = C_PDLY;
                    end
                end
                C_PDLY: begin
                    c_cnt++;
                    if (c_cnt == 4) begin
                        rdpt <= 1'b1;
                        cst = C_E0;
                    end
                end
                C_E0: begin
                    rdpt <= 1'b0;
                    c_k = 0;
                    cst = C_PT;
                end
                C_PT: begin
                    rc4_next(ks);
                    enc <= rc4_pbyte ^ ks;
                    c_k++;
                    if (c_k == 32) cst = C_IDLE;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] byte_of(input logic [255:0] v, input int i);
        return v[255 - 8*i -: 8];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            key_wr = 1'b1;
            key_addr = 5'(i);
            key_data = byte_of(g_key, i);
            msg_wr = 1'b1;
            msg_addr = 5'(i);
            msg_data = byte_of(g_pt, i);
        end
        @(negedge clk);
        key_wr = 1'b0;
        msg_wr = 1'b0;
    endtask

    task automatic go_pulse(input logic [5:0] kl, input logic [5:0] ml);
        @(negedge clk);
        go = 1'b1;
        key_len = kl;
        msg_len = ml;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic run_job(input bit rnd, input bit wr_busy);
        logic [7:0] pd;
        bit pstall;
        ngot = 0;
        ndone = 0;
        nerr = 0;
        stall_bad = 0;
        busy_end = 1;
        ksz = '0;
        pstall = 1'b0;
        pd = '0;
        for (int i = 0; i < 32; i++) got[i] = 'x;
        ready = !rnd;
        go_pulse(6'd32, 6'd32);
        for (int cyc = 0; cyc < 800 && ndone == 0; cyc++) begin
            @(negedge clk);
            key_wr = 1'b0;
            msg_wr = 1'b0;
            if (wr_busy && cyc < 4) begin
                key_wr = 1'b1;
                key_addr = 5'(cyc);
                key_data = 8'hff;
                msg_wr = 1'b1;
                msg_addr = 5'(cyc);
                msg_data = 8'h00;
            end
            if (done) begin
                ndone++;
                busy_end = int'(busy);
            end
            if (error) nerr++;
            if (busy && rc4_ksize != 0) ksz = rc4_ksize;
            if (pstall && (!valid || data !== pd)) stall_bad++;
            if (rnd) ready = 1'($urandom_range(0, 1));
            if (valid && ready) begin
                if (ngot < 32) got[ngot] = data;
                ngot++;
            end
            pstall = valid && !ready;
            pd = data;
        end
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
            if (error) nerr++;
        end
        ready = 1'b1;
    endtask

    task automatic check_job(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_byte%0d", tag, i),
                64'(got[i]), 64'(byte_of(g_ct, i)));
        chk({tag, "_count"}, 64'(ngot), 64'(32));
        chk({tag, "_done"}, 64'(ndone), 64'(1));
        chk({tag, "_err"}, 64'(nerr), 64'(0));
        chk({tag, "_ksize"}, 64'(ksz), 64'(8'h20));
        chk({tag, "_stall"}, 64'(stall_bad), 64'(0));
        chk({tag, "_busy_end"}, 64'(busy_end), 64'(0));
    endtask

    initial begin
        int n;
        int nstart;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs",
            64'({busy, done, error, valid, data, rc4_start, rc4_stop,
                 rc4_hold, rc4_ksize, rc4_kbyte, rc4_pbyte}), 64'(0));
        rst_n = 1'b1;
        load_all();

        run_job(1'b0, 1'b0);
        check_job("golden");

        run_job(1'b1, 1'b0);
        check_job("bp");

        go_pulse(6'd0, 6'd32);
        chk("badkey_err", 64'(error), 64'(1));
        chk("badkey_busy", 64'(busy), 64'(0));
        nstart = 0;
        repeat (8) begin
            @(negedge clk);
            if (rc4_start || busy) nstart++;
        end
        chk("badkey_nostart", 64'(nstart), 64'(0));
        chk("badkey_pulse", 64'(error), 64'(0));

        go_pulse(6'd32, 6'd33);
        chk("badmsg_err", 64'(error), 64'(1));
        nstart = 0;
        repeat (8) begin
            @(negedge clk);
            if (rc4_start || busy) nstart++;
        end
        chk("badmsg_nostart", 64'(nstart), 64'(0));

        stub_en = 1'b0;
        go_pulse(6'd32, 6'd32);
        n = 0;
        while (!error && n < 2200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_err", 64'(error), 64'(1));
        chk("tmo_stop", 64'(rc4_stop), 64'(1));
        chk("tmo_busy", 64'(busy), 64'(0));
        chk("tmo_window", 64'(n >= 2040 && n <= 2060), 64'(1));
        stub_en = 1'b1;
        @(negedge clk);

        go_pulse(6'd32, 6'd32);
        n = 0;
        while (!rdpt && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_rdpt_seen", 64'(n < 500), 64'(1));
        repeat (11) @(negedge clk);
        chk("abort_pt10", 64'(rc4_pbyte), 64'(byte_of(g_pt, 10)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_stop", 64'(rc4_stop), 64'(1));
        chk("abort_busy", 64'(busy), 64'(0));
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || error || valid) n++;
        end
        chk("abort_quiet", 64'(n), 64'(0));
        run_job(1'b0, 1'b0);
        check_job("post_abort");

        run_job(1'b0, 1'b1);
        check_job("wr_busy");
        run_job(1'b0, 1'b0);
        check_job("rerun");

        go_pulse(6'd32, 6'd32);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_ksize", 64'(rc4_ksize), 64'(0));
        rst_n = 1'b1;
        run_job(1'b0, 1'b0);
        check_job("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_stream_ctrl.md
# rc4_stream_ctrl

Sequencer that wraps one `rc4` core and runs one complete encryption job per host command. It holds the host-loaded key and message in local buffers and pulses the core's start. It answers the core's key-copy and plaintext-read requests with byte-per-cycle streams, captures the ciphertext, then returns it to the host over a valid/ready stream. It replaces the ad-hoc feeder logic around the core and is the only block that drives the core's control inputs.

## Interface
- `MAX_KEY`, 32: key buffer depth in bytes; key length range 1..MAX_KEY.
- `MAX_MSG`, 32: message buffer depth in bytes; length range 1..MAX_MSG.
- `TIMEOUT`, 2048: maximum cycles spent waiting for a core request before aborting.
- `CLK_IN` in 1: single clock; all logic on the rising edge.
- `RESET_N_IN` in 1: asynchronous, active-low reset.
- `KEY_WR_IN`, `KEY_ADDR_IN`[4:0], `KEY_DATA_IN`[7:0] in: key buffer write port.
- `MSG_WR_IN`, `MSG_ADDR_IN`[4:0], `MSG_DATA_IN`[7:0] in: message buffer write port.
- `KEY_LEN_IN`[5:0], `MSG_LEN_IN`[5:0] in: lengths, sampled on `GO_IN`.
- `GO_IN` in 1: start job (single-cycle pulse).
- `ABORT_IN` in 1: cancel the job.
- `BUSY_OUT` out 1: high from accepted GO until DONE/ERROR/abort.
- `DONE_OUT` out 1: one-cycle pulse after the last output byte is accepted.
- `ERROR_OUT` out 1: one-cycle pulse on bad length or timeout.
- `OUT_VALID_OUT` out 1, `OUT_DATA_OUT` out [7:0], `OUT_READY_IN` in 1: ciphertext stream.
- `RC4_START_OUT`, `RC4_STOP_OUT`, `RC4_HOLD_OUT` out 1: core controls.
- `RC4_KEY_SIZE_OUT`[7:0], `RC4_KEY_BYTE_OUT`[7:0], `RC4_PLAIN_BYTE_OUT`[7:0] out: core data.
- `RC4_START_KEY_CPY_IN`, `RC4_BUSY_IN`, `RC4_READ_PLAINTEXT_IN` in 1; `RC4_ENC_BYTE_IN`[7:0] in: core status and data.

## Operation
- **States:** IDLE, START, WAIT_KEY, KEY_XFER, WAIT_PT, PT_XFER, DRAIN, OUTPUT.
- **IDLE:** buffer writes are accepted only here; writes while busy are ignored.
  - On `GO_IN` with either length = 0 or above its max: pulse `ERROR_OUT` and stay in IDLE.
  - Otherwise latch the lengths, set `BUSY_OUT`, and go to START.
- **START:** `RC4_START_OUT`=1 for exactly one cycle, then WAIT_KEY.
- **WAIT_KEY:** the edge that samples `RC4_START_KEY_CPY_IN`=1 registers key[0] onto `RC4_KEY_BYTE_OUT` and enters KEY_XFER.
- **KEY_XFER:** each following edge registers the next byte, KEY_LEN bytes in total. After the last byte, go to WAIT_PT with `RC4_KEY_BYTE_OUT` held at 0.
- **WAIT_PT:** the edge that samples `RC4_READ_PLAINTEXT_IN`=1 (edge E0) registers msg[0] and enters PT_XFER. Bytes 1..MSG_LEN-1 follow on consecutive edges; afterwards `RC4_PLAIN_BYTE_OUT`=0.
- **Capture:** ciphertext byte n is sampled from `RC4_ENC_BYTE_IN` at edge E0+2+n into the output buffer. DRAIN covers the captures after the last plaintext byte.
- **End of capture:** after the final capture, pulse `RC4_STOP_OUT` for one cycle and enter OUTPUT.
- **OUTPUT:** `OUT_DATA_OUT`=buf[rd]; transfer on valid&ready.
  - After byte MSG_LEN-1 transfers: clear valid, pulse `DONE_OUT`, drop `BUSY_OUT`, return to IDLE.
  - `OUT_VALID_OUT` stays high and data stays stable while ready is low.
- **Timeout:** a cycle counter runs in WAIT_KEY and WAIT_PT and clears on each state entry. When it reaches TIMEOUT: pulse `RC4_STOP_OUT` and `ERROR_OUT`, go to IDLE.
- **Abort:** `ABORT_IN` in any non-IDLE state pulses `RC4_STOP_OUT`, returns to IDLE, and gives no DONE and no ERROR. Abort has priority over all other same-cycle transitions.
- **Core size and hold:** `RC4_KEY_SIZE_OUT` = latched KEY_LEN zero-extended to 8 bits. `RC4_HOLD_OUT` is tied 0.
- **Counters:** byte counters are 6 bits, and comparisons use length-1.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0. Buffers are not reset.
- **Registered outputs:** every output is registered; no combinational path from inputs to outputs.
- **Key stream latency:** key[k] is on the bus after edge S+k, where S is the edge that samples START_KEY_CPY.
- **Plaintext latency:** msg[n] is on the bus after edge E0+n.
- **Ciphertext latency:** cipher[n] is captured at edge E0+2+n.
- **First output:** `OUT_VALID_OUT` rises the cycle after the STOP pulse.
- **Reset mid-job:** returns to IDLE immediately; the next GO starts a clean job.

## Structure
- **Package `rc4_ctrl_pkg`:** state enum, the default values of MAX_KEY, MAX_MSG and TIMEOUT, and the length width constant.
- **Sub-module:** one `rc4_byte_buf` (MAX×8 register file, 1 write port, 1 async read port). Instantiated three times: key, message, ciphertext.
- **Top-level:** FSM, counters, timeout.

## Test plan
- **Golden vector:** key ae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405, 32 B plaintext 3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595, ready always 1 -> output 2280c9676c8f5c52aba8d42611f85e7ca961a2117d3cfc8236a6051bbfc5f179, one DONE pulse, `RC4_KEY_SIZE_OUT`=0x20.
- **Backpressure:** same job with `OUT_READY_IN` toggling at random -> identical 32 bytes, no byte repeated or dropped, data stable while stalled.
- **Bad lengths:** GO with KEY_LEN=0, then with MSG_LEN=33 -> `ERROR_OUT` pulse only, `RC4_START_OUT` never asserts.
- **Timeout:** core stub never raises START_KEY_CPY -> after 2048 cycles, ERROR and STOP pulse, BUSY low.
- **Abort:** ABORT during PT_XFER at byte 10 -> STOP pulse, no DONE. The next golden job still produces the correct ciphertext.
- **Ignored writes:** key writes while BUSY -> ignored; a rerun without reloading produces the same ciphertext.
